// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared states and helpers for the transmit-side arbiter
package tx_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        REL   = 2'd3
    } state_t;

    localparam int DW_DEF = 8;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_rr_pick.sv
// rtl/tx_arbiter_rr_rr_pick.sv - combinational round-robin picker starting after last_idx
module rr_pick
    import tx_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [2:0]       last_idx,
    output logic [N_SRC-1:0] gnt,
    output logic [2:0]       idx,
    output logic             valid
);

    // Two passes: indices above last_idx first, then wrap to the low ones.
    always_comb begin
        valid = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!valid && req[i] && (3'(i) > last_idx)) begin
                valid  = 1'b1;
                gnt[i] = 1'b1;
                idx    = 3'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (!valid && req[i] && (3'(i) <= last_idx)) begin
                valid  = 1'b1;
                gnt[i] = 1'b1;
                idx    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter_rr.sv
// rtl/tx_arbiter_rr.sv - round-robin bounded-burst share of one packetizer among N byte FIFOs
module tx_arbiter_rr
    import tx_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 8,
    parameter int GRANT_TMO = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_SRC-1:0]    src_mask,
    input  logic [N_SRC-1:0]    src_empty,
    input  logic [N_SRC*DW-1:0] src_data,
    output logic [N_SRC-1:0]    src_rd_en,
    output logic                pk_fifo_empty,
    output logic [DW-1:0]       pk_fifo_data,
    input  logic                pk_rd_en,
    input  logic                pk_tx_busy,
    output logic                pk_tx_ready,
    output logic [N_SRC-1:0]    grant,
    output logic [2:0]          grant_idx,
    output logic                burst_done,
    output logic                proto_err
);

    localparam int BCW = clog2(MAX_BURST + 1);
    localparam int TCW = clog2(GRANT_TMO + 1);

    state_t             state;
    state_t             state_nxt;
    logic [N_SRC-1:0]   req;
    logic [N_SRC-1:0]   pick_gnt;
    logic [2:0]         pick_idx;
    logic               pick_valid;
    logic [2:0]         last_idx;
    logic [BCW-1:0]     burst_cnt;
    logic [TCW-1:0]     tmo_cnt;
    logic               wait_first;
    logic               own_req;

    assign req     = src_mask & ~src_empty;
    assign own_req = |(grant & req);

    rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req      (req),
        .last_idx (last_idx),
        .gnt      (pick_gnt),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB;
            grant       <= '0;
            grant_idx   <= '0;
            last_idx    <= 3'(N_SRC - 1);
            burst_cnt   <= '0;
            tmo_cnt     <= '0;
            wait_first  <= 1'b0;
            pk_tx_ready <= 1'b0;
            burst_done  <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pk_tx_ready <= (state_nxt == GRANT);
            burst_done  <= (state_nxt == REL);
            // Busy rises together with rd_en, so the first WAIT cycle must not look at it.
            wait_first  <= (state_nxt == WAIT) && (state != WAIT);
            tmo_cnt     <= (state == GRANT && state_nxt == GRANT) ? tmo_cnt + 1'b1 : '0;
            if (pk_rd_en && state != GRANT) begin
                proto_err <= 1'b1;
            end
            if (state == ARB && state_nxt == GRANT) begin
                grant     <= pick_gnt;
                grant_idx <= pick_idx;
                burst_cnt <= '0;
            end
            if (state == GRANT && pk_rd_en) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (state_nxt == REL) begin
                grant    <= '0;
                last_idx <= grant_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (en && pick_valid) state_nxt = GRANT;
            end
            GRANT: begin
                if (pk_rd_en) begin
                    state_nxt = WAIT;
                end else if (!own_req || tmo_cnt == TCW'(GRANT_TMO - 1)) begin
                    state_nxt = REL;
                end
            end
            WAIT: begin
                if (!wait_first && !pk_tx_busy) begin
                    state_nxt = (burst_cnt < BCW'(MAX_BURST) && en && own_req) ? GRANT : REL;
                end
            end
            REL:     state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        src_rd_en    = '0;
        pk_fifo_data = '0;
        if (state == GRANT && pk_rd_en) begin
            src_rd_en = grant;
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) pk_fifo_data = src_data[i*DW +: DW];
        end
    end

    assign pk_fifo_empty = ~|(grant & ~src_empty);

endmodule

// File: tb/tb_tx_arbiter_rr.sv
// tb/tb_tx_arbiter_rr.sv - self-checking bench for tx_arbiter_rr with FIFO and packetizer models
module tb_tx_arbiter_rr;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MB    = 8;
    localparam int FRAME = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    src_mask;
    logic [N-1:0]    src_empty;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_rd_en;
    logic            pk_fifo_empty;
    logic [DW-1:0]   pk_fifo_data;
    logic            pk_rd_en;
    logic            pk_tx_busy;
    logic            pk_tx_ready;
    logic [N-1:0]    grant;
    logic [2:0]      grant_idx;
    logic            burst_done;
    logic            proto_err;

    always #5 clk = ~clk;

    tx_arbiter_rr #(.N_SRC(N), .DW(DW), .MAX_BURST(MB), .GRANT_TMO(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .src_mask      (src_mask),
        .src_empty     (src_empty),
        .src_data      (src_data),
        .src_rd_en     (src_rd_en),
        .pk_fifo_empty (pk_fifo_empty),
        .pk_fifo_data  (pk_fifo_data),
        .pk_rd_en      (pk_rd_en),
        .pk_tx_busy    (pk_tx_busy),
        .pk_tx_ready   (pk_tx_ready),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .burst_done    (burst_done),
        .proto_err     (proto_err)
    );

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] cnts;
        int          bursts;
    } vec_t;

    logic [7:0] src_q [N][$];
    exp_t       exp_q [$];
    vec_t       vecs  [6];
    int         checks    = 0;
    int         errors    = 0;
    int         rx_count  = 0;
    int         bursts    = 0;
    int         frame_cnt = 0;
    bit         pk_auto   = 1'b0;
    bit         inj_rd    = 1'b0;

    function automatic logic [7:0] byte_val(input int s, input int k);
        return 8'(8'hA1 + 16 * s + k);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    // Source FIFOs plus a packetizer that launches whenever it is permitted and idle.
    initial begin : pk_model
        logic [N-1:0] popmask;
        exp_t         e;
        popmask    = '0;
        pk_rd_en   = 1'b0;
        pk_tx_busy = 1'b0;
        src_empty  = '1;
        src_data   = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (popmask[i]) begin
                    chk("pop_nonempty", int'(src_q[i].size() > 0), 1);
                    if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                src_empty[i]          = (src_q[i].size() == 0);
                src_data[i*DW +: DW]  = src_empty[i] ? 8'h00 : src_q[i][0];
            end
            #1;
            if (frame_cnt > 0) begin
                frame_cnt--;
                if (frame_cnt == 0) pk_tx_busy = 1'b0;
            end
            pk_rd_en = pk_auto ? 1'b0 : inj_rd;
            if (!rst_n) begin
                pk_tx_busy = 1'b0;
                frame_cnt  = 0;
            end else if (pk_auto && pk_tx_ready && !pk_fifo_empty && !pk_tx_busy) begin
                pk_rd_en   = 1'b1;
                pk_tx_busy = 1'b1;
                frame_cnt  = FRAME;
                rx_count++;
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", int'(pk_fifo_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_src", int'(grant_idx), int'(e.src));
                    chk("rx_data", int'(pk_fifo_data), int'(e.data));
                    #1;
                    chk("rd_strobe_owner", int'(src_rd_en), 1 << e.src);
                end
            end
            #1;
            popmask = src_rd_en;
        end
    end

    initial begin : burst_mon
        forever begin
            @(negedge clk);
            #3;
            if (burst_done) bursts++;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        pk_auto = 1'b0;
        inj_rd  = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        tick();
        tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_grant_idx", int'(grant_idx), 0);
        chk("rst_tx_ready", int'(pk_tx_ready), 0);
        chk("rst_burst_done", int'(burst_done), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        chk("rst_fifo_empty", int'(pk_fifo_empty), 1);
        rst_n = 1'b1;
    endtask

    task automatic load_vec(input logic [3:0] mask, input logic [31:0] cnts);
        int   rem [N];
        int   last;
        int   found;
        int   n;
        int   j;
        bit   more;
        exp_t e;
        for (int s = 0; s < N; s++) begin
            rem[s] = int'(cnts[s*8 +: 8]);
            for (int k = 0; k < rem[s]; k++) src_q[s].push_back(byte_val(s, k));
        end
        last = N - 1;
        more = 1'b1;
        while (more) begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                j = (last + k) % N;
                if (found < 0 && mask[j] && rem[j] > 0) found = j;
            end
            if (found < 0) begin
                more = 1'b0;
            end else begin
                n = (rem[found] < MB) ? rem[found] : MB;
                for (int b = 0; b < n; b++) begin
                    e.src  = 3'(found);
                    e.data = byte_val(found, int'(cnts[found*8 +: 8]) - rem[found] + b);
                    exp_q.push_back(e);
                end
                rem[found] -= n;
                last = found;
            end
        end
    endtask

    initial begin : main
        int   t;
        int   b0;
        int   r0;
        bit   seen;
        exp_t e;

        vecs[0] = '{4'hF,    {8'd0,  8'd3,  8'd0,  8'd3},  2};
        vecs[1] = '{4'hF,    {8'd20, 8'd20, 8'd20, 8'd20}, 12};
        vecs[2] = '{4'hF,    {8'd0,  8'd2,  8'd1,  8'd0},  2};
        vecs[3] = '{4'b1010, {8'd5,  8'd5,  8'd5,  8'd5},  2};
        vecs[4] = '{4'hF,    {8'd0,  8'd0,  8'd0,  8'd9},  2};
        vecs[5] = '{4'hF,    {8'd1,  8'd0,  8'd0,  8'd0},  1};

        rst_n    = 1'b0;
        en       = 1'b0;
        src_mask = '0;

        for (int v = 0; v < 6; v++) begin
            en = 1'b0;
            do_reset();
            b0       = bursts;
            src_mask = vecs[v].mask;
            load_vec(vecs[v].mask, vecs[v].cnts);
            pk_auto  = 1'b1;
            en       = 1'b1;
            t = 0;
            while (t < 3000 && !(exp_q.size() == 0 && !pk_tx_busy && grant == '0)) begin
                tick();
                t++;
            end
            repeat (4) tick();
            chk($sformatf("v%0d_bytes_left", v), exp_q.size(), 0);
            chk($sformatf("v%0d_bursts", v), bursts - b0, vecs[v].bursts);
            chk($sformatf("v%0d_proto_err", v), int'(proto_err), 0);
            chk($sformatf("v%0d_idle_ready", v), int'(pk_tx_ready), 0);
        end

        // Grant timeout with a silent packetizer, then rotation to the next source.
        en = 1'b0;
        do_reset();
        src_q[0].push_back(8'h11);
        src_q[1].push_back(8'h22);
        src_mask = 4'hF;
        en       = 1'b1;
        t = 0;
        while (t < 20 && !pk_tx_ready) begin
            tick();
            t++;
        end
        chk("tmo_first_grant", int'(grant), 1);
        t = 0;
        while (t < 40 && pk_tx_ready) begin
            tick();
            t++;
        end
        chk("tmo_ready_cycles", t, 16);
        chk("tmo_burst_done", int'(burst_done), 1);
        chk("tmo_grant_released", int'(grant), 0);
        tick();
        tick();
        chk("tmo_grant_rotated", int'(grant), 2);
        chk("tmo_proto_err", int'(proto_err), 0);

        // Read strobe outside GRANT.
        en = 1'b0;
        do_reset();
        src_q[1].push_back(8'h33);
        src_mask = 4'hF;
        tick();
        tick();
        inj_rd = 1'b1;
        tick();
        chk("proto_no_strobe", int'(src_rd_en), 0);
        inj_rd = 1'b0;
        tick();
        chk("proto_err_set", int'(proto_err), 1);
        tick();
        chk("proto_err_sticky", int'(proto_err), 1);
        chk("proto_no_grant", int'(grant), 0);

        // en dropped while the second byte of a burst is in flight.
        do_reset();
        for (int k = 0; k < 5; k++) src_q[0].push_back(byte_val(0, k));
        for (int k = 0; k < 2; k++) begin
            e.src  = 3'd0;
            e.data = byte_val(0, k);
            exp_q.push_back(e);
        end
        src_mask = 4'hF;
        r0       = rx_count;
        b0       = bursts;
        pk_auto  = 1'b1;
        en       = 1'b1;
        t = 0;
        while (t < 200 && rx_count - r0 < 2) begin
            tick();
            t++;
        end
        en = 1'b0;
        t = 0;
        while (t < 50 && pk_tx_busy) begin
            tick();
            t++;
        end
        tick();
        chk("endrop_grant_zero", int'(grant), 0);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (pk_tx_ready) seen = 1'b1;
        end
        chk("endrop_ready_low", int'(seen), 0);
        chk("endrop_bytes", rx_count - r0, 2);
        chk("endrop_left_in_fifo", src_q[0].size(), 3);
        chk("endrop_bursts", bursts - b0, 1);

        // Reset in the middle of a frame.
        do_reset();
        src_q[0].push_back(byte_val(0, 0));
        src_q[0].push_back(byte_val(0, 1));
        src_q[1].push_back(byte_val(1, 0));
        src_q[1].push_back(byte_val(1, 1));
        e.src  = 3'd0;
        e.data = byte_val(0, 0);
        exp_q.push_back(e);
        src_mask = 4'hF;
        r0       = rx_count;
        pk_auto  = 1'b1;
        en       = 1'b1;
        t = 0;
        while (t < 50 && rx_count - r0 < 1) begin
            tick();
            t++;
        end
        tick();
        pk_auto = 1'b0;
        rst_n   = 1'b0;
        tick();
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_ready", int'(pk_tx_ready), 0);
        chk("midrst_proto_err", int'(proto_err), 0);
        exp_q.delete();
        rst_n = 1'b1;
        t = 0;
        while (t < 20 && grant == '0) begin
            tick();
            t++;
        end
        chk("midrst_first_owner", int'(grant), 1);
        chk("midrst_first_idx", int'(grant_idx), 0);

        en = 1'b0;
        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
